// File: rtl/apu_arb_pkg.sv
// apu_arb_pkg: shared tag-width helper, default core-id width and per-core outstanding-count type.
package apu_arb_pkg;
    function automatic int core_idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
    localparam int CORE_IDW = core_idw(4);
    typedef logic [3:0] cnt_t;
endpackage

// File: rtl/apu_share_arbiter_rr_select.sv
// rr_select: picks the first requesting index at or after the pointer, wrapping around.
module rr_select #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] onehot_o,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);
    int j;
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        // Scan farthest offset first so the closest requester is written last and wins.
        for (int o = N - 1; o >= 0; o--) begin
            j = (int'(ptr_i) + o) % N;
            if (req_i[j]) begin
                idx_o   = W'(j);
                valid_o = 1'b1;
            end
        end
        onehot_o = valid_o ? (N'(1) << idx_o) : '0;
    end
endmodule

// File: rtl/apu_share_arbiter.sv
// apu_share_arbiter: round-robin sharing of one FPU among cores with per-core outstanding limits.
// Optional per-core grant and stall counters are built when APU_ARB_PERF_EN is defined.
module apu_share_arbiter import apu_arb_pkg::*; #(
    parameter int NB_CORES        = 4,
    parameter int NB_ARGS         = 2,
    parameter int OPCODE_WIDTH    = 6,
    parameter int DATA_WIDTH      = 32,
    parameter int FLAGS_IN_WIDTH  = 15,
    parameter int FLAGS_OUT_WIDTH = 5,
    parameter int MAX_OUTST       = 4,
    localparam int IDW            = core_idw(NB_CORES)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NB_CORES-1:0]                     core_req_i,
    output logic [NB_CORES-1:0]                     core_gnt_o,
    input  logic [NB_CORES*NB_ARGS*DATA_WIDTH-1:0]  core_operands_i,
    input  logic [NB_CORES*OPCODE_WIDTH-1:0]        core_op_i,
    input  logic [NB_CORES*FLAGS_IN_WIDTH-1:0]      core_flags_i,
    output logic [NB_CORES-1:0]                     core_rvalid_o,
    output logic [DATA_WIDTH-1:0]                   core_rdata_o,
    output logic [FLAGS_OUT_WIDTH-1:0]              core_rflags_o,
    output logic                                    fpu_req_o,
    input  logic                                    fpu_gnt_i,
    output logic [NB_ARGS*DATA_WIDTH-1:0]           fpu_operands_o,
    output logic [OPCODE_WIDTH-1:0]                 fpu_op_o,
    output logic [FLAGS_IN_WIDTH-1:0]               fpu_flags_o,
    output logic [IDW-1:0]                          fpu_id_o,
    input  logic                                    fpu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                   fpu_rdata_i,
    input  logic [FLAGS_OUT_WIDTH-1:0]              fpu_rflags_i,
    input  logic [IDW-1:0]                          fpu_rid_i,
    output logic                                    proto_err_o,
    output logic [NB_CORES*32-1:0]                  perf_gnt_cnt_o,
    output logic [31:0]                             perf_stall_cnt_o
);
    cnt_t                 cnt_q [NB_CORES];
    cnt_t                 cnt_d [NB_CORES];
    logic [IDW-1:0]       ptr_q, lock_id_q, rr_idx, sel;
    logic                 lock_q, rr_v, gnt, rsp_ok, rsp_bad;
    logic [NB_CORES-1:0]  elig, rr_oh, rvalid_q;
    logic [DATA_WIDTH-1:0]      rdata_q;
    logic [FLAGS_OUT_WIDTH-1:0] rflags_q;
    logic                 perr_q;
    always_comb begin
        elig = '0;
        for (int i = 0; i < NB_CORES; i++) elig[i] = core_req_i[i] && (cnt_q[i] < cnt_t'(MAX_OUTST));
    end
    rr_select #(.N(NB_CORES), .W(IDW)) u_rr_select (
        .req_i   (elig),
        .ptr_i   (ptr_q),
        .onehot_o(rr_oh),
        .idx_o   (rr_idx),
        .valid_o (rr_v)
    );
    // A stalled request keeps its core until granted or withdrawn, even if a higher-priority core appears.
    assign sel            = (lock_q && elig[lock_id_q]) ? lock_id_q : rr_idx;
    assign fpu_req_o      = rr_v && !rst;
    assign gnt            = fpu_req_o && fpu_gnt_i;
    assign core_gnt_o     = gnt ? (NB_CORES'(1) << sel) : '0;
    assign fpu_operands_o = core_operands_i[sel*NB_ARGS*DATA_WIDTH +: NB_ARGS*DATA_WIDTH];
    assign fpu_op_o       = core_op_i[sel*OPCODE_WIDTH +: OPCODE_WIDTH];
    assign fpu_flags_o    = core_flags_i[sel*FLAGS_IN_WIDTH +: FLAGS_IN_WIDTH];
    assign fpu_id_o       = sel;
    assign rsp_ok         = fpu_rvalid_i && (int'(fpu_rid_i) < NB_CORES) && (cnt_q[fpu_rid_i] != '0);
    assign rsp_bad        = fpu_rvalid_i && !rsp_ok;
    always_comb begin
        for (int i = 0; i < NB_CORES; i++)
            cnt_d[i] = cnt_q[i] + cnt_t'(core_gnt_o[i]) - cnt_t'(rsp_ok && (fpu_rid_i == IDW'(i)));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '{default: '0};
            ptr_q     <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            rvalid_q  <= '0;
            rdata_q   <= '0;
            rflags_q  <= '0;
            perr_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            if (gnt) ptr_q <= (sel == IDW'(NB_CORES - 1)) ? '0 : sel + 1'b1;
            lock_q    <= fpu_req_o && !fpu_gnt_i;
            lock_id_q <= sel;
            rvalid_q  <= rsp_ok ? (NB_CORES'(1) << fpu_rid_i) : '0;
            if (rsp_ok) begin
                rdata_q  <= fpu_rdata_i;
                rflags_q <= fpu_rflags_i;
            end
            if (rsp_bad) perr_q <= 1'b1;
        end
    end
    assign core_rvalid_o = rvalid_q;
    assign core_rdata_o  = rdata_q;
    assign core_rflags_o = rflags_q;
    assign proto_err_o   = perr_q;
`ifdef APU_ARB_PERF_EN
    logic [31:0] perf_gnt_q [NB_CORES];
    logic [31:0] perf_stall_q;
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB_CORES; i++) begin
            if (rst) perf_gnt_q[i] <= '0;
            else if (core_gnt_o[i] && perf_gnt_q[i] != '1) perf_gnt_q[i] <= perf_gnt_q[i] + 1'b1;
        end
        if (rst) perf_stall_q <= '0;
        else if (fpu_req_o && !fpu_gnt_i && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 1'b1;
    end
    always_comb begin
        perf_gnt_cnt_o = '0;
        for (int i = 0; i < NB_CORES; i++) perf_gnt_cnt_o[i*32 +: 32] = perf_gnt_q[i];
    end
    assign perf_stall_cnt_o = perf_stall_q;
`else
    assign perf_gnt_cnt_o   = '0;
    assign perf_stall_cnt_o = '0;
`endif
endmodule

// File: doc/apu_share_arbiter.md
APU_SHARE_ARBITER -- requirements
Module: apu_share_arbiter

Interface
REQ-001 SHALL have parameter NB_CORES, default 4: number of requesting cores (2..16).
REQ-002 SHALL have parameter NB_ARGS, default 2: operands per request.
REQ-003 SHALL have parameter OPCODE_WIDTH, default 6: width of the APU op field.
REQ-004 SHALL have parameter DATA_WIDTH, default 32: operand and result width.
REQ-005 SHALL have parameter FLAGS_IN_WIDTH, default 15: request flags width.
REQ-006 SHALL have parameter FLAGS_OUT_WIDTH, default 5: response status width.
REQ-007 SHALL have parameter MAX_OUTST, default 4: per-core outstanding-operation limit (1..15).
REQ-008 SHALL use one clock and a synchronous, active-high reset: clk, input, 1, rising-edge clock; rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have ports core_req_i, input, NB_CORES, per-core request; core_gnt_o, output, NB_CORES, per-core grant.
REQ-010 SHALL have ports core_operands_i, input, NB_CORES x NB_ARGS x DATA_WIDTH; core_op_i, input, NB_CORES x OPCODE_WIDTH; core_flags_i, input, NB_CORES x FLAGS_IN_WIDTH.
REQ-011 SHALL have ports core_rvalid_o, output, NB_CORES, per-core response pulse; core_rdata_o, output, DATA_WIDTH, shared result; core_rflags_o, output, FLAGS_OUT_WIDTH, shared status.
REQ-012 SHALL have FPU-side ports fpu_req_o, output, 1; fpu_gnt_i, input, 1; fpu_operands_o, fpu_op_o, fpu_flags_o, outputs, selected request fields; fpu_id_o, output, CORE_IDW, requester index as tag.
REQ-013 SHALL have FPU response ports fpu_rvalid_i, input, 1; fpu_rdata_i, input, DATA_WIDTH; fpu_rflags_i, input, FLAGS_OUT_WIDTH; fpu_rid_i, input, CORE_IDW, returned tag.
REQ-014 SHALL have port proto_err_o, output, 1, sticky protocol-error flag.

Function
REQ-015 SHALL treat a core as eligible when core_req_i is high and its outstanding count is below MAX_OUTST.
REQ-016 SHALL select combinationally the first eligible core at or after the round-robin pointer, wrapping from NB_CORES-1 to 0.
REQ-017 SHALL drive fpu_req_o high if any core is eligible and route that core's fields and index to fpu_*_o.
REQ-018 SHALL assert core_gnt_o[i] only when core i is selected and fpu_gnt_i is high, at most one bit per cycle.
REQ-019 SHALL, on a grant to core k, set the pointer to (k+1) mod NB_CORES at the next edge; with no grant the pointer holds.
REQ-020 SHALL hold the selection stable while fpu_req_o is high and fpu_gnt_i is low, unless the selected core drops its request.
REQ-021 SHALL increment core k's count on a grant, decrement it on fpu_rvalid_i with fpu_rid_i==k, and hold it when both happen in the same cycle.
REQ-022 SHALL register responses: core_rvalid_o[fpu_rid_i] pulses exactly one cycle after fpu_rvalid_i, with rdata/rflags registered alongside.
REQ-023 SHALL never backpressure responses, accepting one per cycle.
REQ-024 SHALL set proto_err_o on a response whose core count is zero or whose fpu_rid_i is at least NB_CORES, drop that response, and leave counts unchanged.

Reset
REQ-025 SHALL, while rst is high, clear the pointer, all counts, core_rvalid_o, core_rdata_o, core_rflags_o and proto_err_o, and force fpu_req_o and core_gnt_o low.
REQ-026 SHALL discard FPU responses arriving during reset and apply no count changes.

Configuration
REQ-027 SHALL, with APU_ARB_PERF_EN defined, provide perf_gnt_cnt_o (NB_CORES x 32) counting grants per core and perf_stall_cnt_o (32) counting cycles with fpu_req_o high and fpu_gnt_i low; both saturate and are cleared by rst.
REQ-028 SHALL, without APU_ARB_PERF_EN, keep the perf ports and tie them to zero with no counter flops.

Structure
REQ-029 SHALL place CORE_IDW = max(1, clog2(NB_CORES)) and the count type in the shared package apu_arb_pkg.
REQ-030 SHALL implement the pointer-based selection in the sub-module rr_select (req vector and pointer in, one-hot plus index out).

Verification
REQ-031 With all 4 cores requesting, fpu_gnt_i=1 and pointer 0, grants SHALL be cores 0,1,2,3,0 on consecutive cycles.
REQ-032 With core 2 holding 4 outstanding and requesting, core 2 SHALL get no grant; a response with rid=2 SHALL allow a grant in the following cycle.
REQ-033 With fpu_rvalid_i=1, rid=1 and data 0x3F800000 at cycle n, core_rvalid_o SHALL equal 4'b0010 with rdata 0x3F800000 at cycle n+1.
REQ-034 A grant and a response for core 0 in the same cycle with count 1 SHALL leave the count at 1.
REQ-035 A response with rid=3 when core 3's count is 0 SHALL set proto_err_o, produce no core_rvalid_o, and proto_err_o SHALL stay set until rst.
REQ-036 Asserting rst for one cycle with counts at 2 SHALL clear the counts, pointer and proto_err_o, and make grants start from core 0.
